// File: rtl/cb_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : cb_pkg
// Brief  : Shared constants, handshake FSM encoding and helpers for cb_*.
// Rev    : 1.0 - initial release
// ============================================================================
package cb_pkg;

  localparam int CB_SYNC_MIN = 2;
  localparam int CB_SYNC_MAX = 4;

  localparam logic [0:0] CB_HS_IDLE     = 1'b0;
  localparam logic [0:0] CB_HS_WAIT_ACK = 1'b1;

  function automatic int cb_clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cb_sync_bit.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : cb_sync_bit
// Brief  : STAGES-deep single-bit synchronizer, async reset to 0.
// Rev    : 1.0 - initial release
// ============================================================================
module cb_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/cb_cross_bus_hs.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : cb_cross_bus_hs
// Brief  : Queued toggle req/ack bus CDC, clk_src -> clk_dest, valid/ready out.
// Rev    : 1.0 - initial release
// ============================================================================
module cb_cross_bus_hs
  import cb_pkg::*;
#(
  parameter int U_DLY       = 1,
  parameter int DAT_WIDTH   = 32,
  parameter int SRC_DEPTH   = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 rst_n,
  input  logic                 clk_src,
  input  logic                 clk_dest,
  input  logic                 dat_src_strb,
  input  logic [DAT_WIDTH-1:0] dat_src,
  output logic                 src_full,
  output logic [CNT_WIDTH-1:0] src_drop_cnt,
  output logic                 dat_dest_vld,
  output logic [DAT_WIDTH-1:0] dat_dest,
  input  logic                 dat_dest_rdy
);

  localparam int C_SYNC = (SYNC_STAGES < CB_SYNC_MIN) ? CB_SYNC_MIN :
                          (SYNC_STAGES > CB_SYNC_MAX) ? CB_SYNC_MAX : SYNC_STAGES;
  localparam int C_PTR_W = cb_clog2(SRC_DEPTH);
  localparam logic [C_PTR_W:0] C_DEPTH = (C_PTR_W+1)'(SRC_DEPTH);

  // U_DLY only matters to delay-annotated simulation models; this RTL has none.
  logic w_unused_udly;
  assign w_unused_udly = (U_DLY != 0);

  // ---------------- source domain ----------------
  logic [DAT_WIDTH-1:0] mem_q [SRC_DEPTH];
  logic [C_PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [C_PTR_W:0]     cnt_q, cnt_d;
  logic                 full_q;
  logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic [0:0]           state_q, state_d;
  logic                 req_tgl_q;
  logic [DAT_WIDTH-1:0] hold_q;
  logic                 w_ack_sync, w_pop, w_wr, w_drop;

  // ---------------- destination domain ----------------
  logic                 w_req_sync, w_evt, w_capture;
  logic                 req_seen_q, pending_q, pending_d, vld_q, vld_d, ack_tgl_q;
  logic [DAT_WIDTH-1:0] dat_dest_q;

  cb_sync_bit #(.STAGES(C_SYNC)) u_sync_ack (
    .clk   (clk_src),
    .rst_n (rst_n),
    .d_i   (ack_tgl_q),
    .q_o   (w_ack_sync)
  );

  cb_sync_bit #(.STAGES(C_SYNC)) u_sync_req (
    .clk   (clk_dest),
    .rst_n (rst_n),
    .d_i   (req_tgl_q),
    .q_o   (w_req_sync)
  );

  always_ff @(posedge clk_src or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CB_HS_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      CB_HS_IDLE:     if (cnt_q != '0) state_d = CB_HS_WAIT_ACK;
      CB_HS_WAIT_ACK: if (w_ack_sync == req_tgl_q) state_d = CB_HS_IDLE;
      default:        state_d = CB_HS_IDLE;
    endcase
  end

  always_comb begin
    w_pop = (state_q == CB_HS_IDLE) && (cnt_q != '0);
  end

  // A write into a full queue still succeeds when the head leaves this cycle.
  assign w_wr   = dat_src_strb && ((cnt_q != C_DEPTH) || w_pop);
  assign w_drop = dat_src_strb && !w_wr;

  always_comb begin
    cnt_d = cnt_q;
    if (w_wr && !w_pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!w_wr && w_pop) begin
      cnt_d = cnt_q - 1'b1;
    end
    drop_cnt_d = drop_cnt_q;
    if (w_drop && (drop_cnt_q != '1)) begin
      drop_cnt_d = drop_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_src) begin
    if (w_wr) begin
      mem_q[wr_ptr_q] <= dat_src;
    end
  end

  always_ff @(posedge clk_src or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      full_q     <= 1'b0;
      drop_cnt_q <= '0;
      req_tgl_q  <= 1'b0;
      hold_q     <= '0;
    end else begin
      cnt_q      <= cnt_d;
      full_q     <= (cnt_d == C_DEPTH);
      drop_cnt_q <= drop_cnt_d;
      if (w_wr) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      // hold_q is sampled by clk_dest; it only changes while no request is open.
      if (w_pop) begin
        hold_q    <= mem_q[rd_ptr_q];
        rd_ptr_q  <= rd_ptr_q + 1'b1;
        req_tgl_q <= ~req_tgl_q;
      end
    end
  end

  assign src_full     = full_q;
  assign src_drop_cnt = drop_cnt_q;

  // ---------------- destination logic ----------------
  assign w_evt     = w_req_sync ^ req_seen_q;
  assign w_capture = pending_q && (!vld_q || dat_dest_rdy);

  always_comb begin
    pending_d = pending_q | w_evt;
    vld_d     = vld_q;
    if (w_capture) begin
      pending_d = 1'b0;
      vld_d     = 1'b1;
    end else if (vld_q && dat_dest_rdy) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_dest or negedge rst_n) begin
    if (!rst_n) begin
      req_seen_q <= 1'b0;
      pending_q  <= 1'b0;
      vld_q      <= 1'b0;
      ack_tgl_q  <= 1'b0;
      dat_dest_q <= '0;
    end else begin
      req_seen_q <= w_req_sync;
      pending_q  <= pending_d;
      vld_q      <= vld_d;
      if (w_capture) begin
        dat_dest_q <= hold_q;
        ack_tgl_q  <= ~ack_tgl_q;
      end
    end
  end

  assign dat_dest_vld = vld_q;
  assign dat_dest     = dat_dest_q;

endmodule
`default_nettype wire

// File: tb/tb_cb_cross_bus_hs.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_cb_cross_bus_hs
// Brief  : Directed scoreboard bench for cb_cross_bus_hs.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_cb_cross_bus_hs;

  logic        clk_src  = 1'b0;
  logic        clk_dest = 1'b0;
  logic        rst_n    = 1'b0;
  logic        strb     = 1'b0;
  logic        rdy      = 1'b0;
  logic [31:0] dsrc     = '0;
  logic        src_full;
  logic [1:0]  drop_cnt;
  logic        vld;
  logic [31:0] dat_dest;

  realtime src_half  = 5.0;
  realtime dest_half = 14.0;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];

  always #(src_half)  clk_src  = ~clk_src;
  always #(dest_half) clk_dest = ~clk_dest;

  cb_cross_bus_hs #(
    .U_DLY       (1),
    .DAT_WIDTH   (32),
    .SRC_DEPTH   (4),
    .SYNC_STAGES (2),
    .CNT_WIDTH   (2)
  ) dut (
    .rst_n        (rst_n),
    .clk_src      (clk_src),
    .clk_dest     (clk_dest),
    .dat_src_strb (strb),
    .dat_src      (dsrc),
    .src_full     (src_full),
    .src_drop_cnt (drop_cnt),
    .dat_dest_vld (vld),
    .dat_dest     (dat_dest),
    .dat_dest_rdy (rdy)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // rdy only changes just after a clk_dest rise, so vld&&rdy seen here is the next transfer.
  always @(negedge clk_dest) begin
    logic [31:0] e;
    if (rst_n === 1'b1 && vld === 1'b1 && rdy === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $error("FAIL unexpected_word: observed %h expected none", dat_dest);
      end else begin
        e = exp_q.pop_front();
        chk("dat_dest", {32'h0, dat_dest}, {32'h0, e});
      end
    end
  end

  task automatic burst(input int n, input logic [31:0] base, input int n_exp);
    for (int i = 0; i < n_exp; i++) exp_q.push_back(base + 32'(i));
    for (int i = 0; i < n; i++) begin
      @(negedge clk_src);
      strb = 1'b1;
      dsrc = base + 32'(i);
    end
    @(negedge clk_src);
    strb = 1'b0;
  endtask

  task automatic set_rdy(input logic v);
    @(posedge clk_dest);
    #1 rdy = v;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk_dest);
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    repeat (20) @(negedge clk_dest);
  endtask

  task automatic wait_vld(input int budget);
    int k = 0;
    while (vld !== 1'b1 && k < budget) begin
      @(negedge clk_dest);
      k++;
    end
    chk("vld_timeout", {63'h0, vld}, 64'd1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    repeat (3) @(negedge clk_src);
    chk("rst_full", {63'h0, src_full}, 64'd0);
    chk("rst_drop", {62'h0, drop_cnt}, 64'd0);
    chk("rst_vld",  {63'h0, vld}, 64'd0);
    chk("rst_dat",  {32'h0, dat_dest}, 64'd0);
    @(negedge clk_src);
    rst_n = 1'b1;
    set_rdy(1'b1);

    // single word
    burst(1, 32'hA5A5_0001, 1);
    drain(100);
    chk("single_drop", {62'h0, drop_cnt}, 64'd0);
    chk("single_vld_low", {63'h0, vld}, 64'd0);

    // burst of four
    burst(4, 32'd1, 4);
    drain(200);
    chk("burst_full", {63'h0, src_full}, 64'd0);
    chk("burst_drop", {62'h0, drop_cnt}, 64'd0);

    // overflow: one popped, four queued, two dropped
    dest_half = 50.0;
    repeat (2) @(negedge clk_dest);
    burst(7, 32'd1, 5);
    chk("ovf_full", {63'h0, src_full}, 64'd1);
    chk("ovf_drop", {62'h0, drop_cnt}, 64'd2);
    for (int i = 0; i < 200 && src_full !== 1'b0; i++) @(negedge clk_src);
    chk("ovf_full_clear", {63'h0, src_full}, 64'd0);
    drain(200);
    burst(10, 32'd11, 5);
    chk("ovf_drop_sat", {62'h0, drop_cnt}, 64'd3);
    drain(200);
    chk("ovf_drop_hold", {62'h0, drop_cnt}, 64'd3);

    // backpressure
    dest_half = 14.0;
    set_rdy(1'b0);
    burst(3, 32'h101, 3);
    wait_vld(100);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_dest);
      chk("bp_hold", {31'h0, vld, dat_dest}, {31'h0, 1'b1, 32'h101});
    end
    set_rdy(1'b1);
    drain(200);

    // consume and capture on the same edge
    src_half  = 2.5;
    dest_half = 10.0;
    set_rdy(1'b0);
    burst(2, 32'h201, 2);
    wait_vld(100);
    repeat (20) @(negedge clk_dest);
    set_rdy(1'b1);
    repeat (2) @(negedge clk_dest);
    chk("swap_vld_dat", {31'h0, vld, dat_dest}, {31'h0, 1'b1, 32'h202});
    drain(100);
    burst(5, 32'h211, 5);
    drain(200);

    // reset while a word is in flight with two queued
    src_half  = 5.0;
    dest_half = 50.0;
    repeat (2) @(negedge clk_dest);
    burst(3, 32'h301, 0);
    rst_n = 1'b0;
    repeat (3) @(negedge clk_src);
    chk("mid_rst_full", {63'h0, src_full}, 64'd0);
    chk("mid_rst_drop", {62'h0, drop_cnt}, 64'd0);
    chk("mid_rst_vld",  {63'h0, vld}, 64'd0);
    chk("mid_rst_dat",  {32'h0, dat_dest}, 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_dest);
      chk("post_rst_vld", {63'h0, vld}, 64'd0);
    end
    burst(1, 32'h0000_BEEF, 1);
    drain(100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
